// File: rtl/boot_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : boot_load_ctrl
//  Description : Program-load sequencer and instruction-BRAM write-port
//                arbiter. Gives the BRAM port to the UART loader while a
//                load runs, holding the CPU in reset. It ends the load after
//                an idle timeout on the FIFO, then hands the port to the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_load_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_WORDS    = 256,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start_load,
  input  logic                  i_loader_we,
  input  logic [ADDR_WIDTH-1:0] i_loader_addr,
  input  logic [DATA_WIDTH-1:0] i_loader_data,
  input  logic                  i_fifo_empty,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic                  o_bram_we,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0] o_bram_wdata,
  output logic                  o_cpu_rst,
  output logic                  o_load_done,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_overflow,
  output logic [1:0]            o_state
);

  localparam int TIMER_W = $clog2(IDLE_TIMEOUT);
  localparam logic [ADDR_WIDTH:0] c_max_words  = (ADDR_WIDTH+1)'(MAX_WORDS);
  localparam logic [TIMER_W-1:0]  c_timer_last = TIMER_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_DONE = 2'b10,
    ST_RUN  = 2'b11
  } state_t;

  state_t                r_state;
  logic                  r_bram_we;
  logic [ADDR_WIDTH-1:0] r_bram_addr;
  logic [DATA_WIDTH-1:0] r_bram_wdata;
  logic                  r_cpu_rst;
  logic                  r_load_done;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_overflow;
  logic [TIMER_W-1:0]    r_timer;

  logic w_can_accept;
  logic w_timeout;

  // Room left for another loader word, and idle-timeout expiry (only armed
  // once at least one word has arrived, so an empty load waits forever).
  assign w_can_accept = (r_word_count < c_max_words);
  assign w_timeout    = (r_word_count != '0) && (r_timer == c_timer_last);

  // Load sequencer FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_bram_we    <= 1'b0;
      r_bram_addr  <= '0;
      r_bram_wdata <= '0;
      r_cpu_rst    <= 1'b1;
      r_load_done  <= 1'b0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_bram_we   <= 1'b0;
      r_load_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cpu_rst <= 1'b1;
          if (i_loader_we) r_overflow <= 1'b1;
          if (i_start_load) begin
            r_state      <= ST_LOAD;
            r_word_count <= '0;
            r_timer      <= '0;
            // A loader strobe coinciding with the start is dropped and flagged.
            r_overflow   <= i_loader_we;
          end
        end
        ST_LOAD: begin
          r_cpu_rst <= 1'b1;
          if (i_loader_we) begin
            r_timer <= '0;
            if (w_can_accept) begin
              r_bram_we    <= 1'b1;
              r_bram_addr  <= i_loader_addr;
              r_bram_wdata <= i_loader_data;
              r_word_count <= r_word_count + 1'b1;
            end else begin
              r_overflow <= 1'b1;
            end
          end else if (i_fifo_empty) begin
            if (w_timeout) begin
              r_state     <= ST_DONE;
              r_load_done <= 1'b1;
            end else if (r_timer != c_timer_last) begin
              r_timer <= r_timer + 1'b1;
            end
          end else begin
            r_timer <= '0;
          end
        end
        ST_DONE: begin
          // CPU reset drops in the same edge that enters RUN.
          r_state   <= ST_RUN;
          r_cpu_rst <= 1'b0;
          if (i_loader_we) r_overflow <= 1'b1;
        end
        ST_RUN: begin
          if (i_start_load) begin
            r_state      <= ST_LOAD;
            r_cpu_rst    <= 1'b1;
            r_word_count <= '0;
            r_timer      <= '0;
            r_overflow   <= i_loader_we;
          end else begin
            r_cpu_rst    <= 1'b0;
            r_bram_we    <= i_cpu_we;
            r_bram_addr  <= i_cpu_addr;
            r_bram_wdata <= i_cpu_wdata;
            if (i_loader_we) r_overflow <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cpu_rst <= 1'b1;
        end
      endcase
    end
  end

  assign o_bram_we    = r_bram_we;
  assign o_bram_addr  = r_bram_addr;
  assign o_bram_wdata = r_bram_wdata;
  assign o_cpu_rst    = r_cpu_rst;
  assign o_load_done  = r_load_done;
  assign o_word_count = r_word_count;
  assign o_overflow   = r_overflow;
  assign o_state      = r_state;

endmodule
`default_nettype wire
